// File: rtl/decode_issue_queue_pkg.sv
// rtl/decode_issue_queue_pkg.sv - shared decoded-instruction bundle and queue defaults
package Public_Info;

  localparam int QUEUE_DEPTH = 8;

  typedef enum logic [1:0] {
    OP_ALU = 2'd0,
    OP_MEM = 2'd1,
    OP_BR  = 2'd2,
    OP_SYS = 2'd3
  } op_class_e;

  typedef struct packed {
    logic        o_valid;
    logic [31:0] PC;
    logic [31:0] instr;
    op_class_e   op;
    logic [4:0]  rd;
  } PC_set;

endpackage

// File: rtl/decode_issue_queue_iq_ram.sv
// rtl/decode_issue_queue_iq_ram.sv - unreset entry array, two write ports, two async read ports
module iq_ram
  import Public_Info::*;
#(
  parameter int DEPTH = QUEUE_DEPTH,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en0,
  input  logic [PW-1:0] wr_addr0,
  input  PC_set         wr_data0,
  input  logic          wr_en1,
  input  logic [PW-1:0] wr_addr1,
  input  PC_set         wr_data1,
  input  logic [PW-1:0] rd_addr0,
  output PC_set         rd_data0,
  input  logic [PW-1:0] rd_addr1,
  output PC_set         rd_data1
);

  PC_set mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en0) mem[wr_addr0] <= wr_data0;
    if (wr_en1) mem[wr_addr1] <= wr_data1;
  end

  assign rd_data0 = mem[rd_addr0];
  assign rd_data1 = mem[rd_addr1];

endmodule

// File: rtl/decode_issue_queue.sv
// rtl/decode_issue_queue.sv - two-wide in-order decode-to-dispatch queue
module decode_issue_queue
  import Public_Info::*;
#(
  parameter int DEPTH = QUEUE_DEPTH
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     flush,
  input  PC_set                    i_set1,
  input  PC_set                    i_set2,
  input  logic [1:0]               i_push,
  output logic                     o_ready,
  output PC_set                    o_set1,
  output PC_set                    o_set2,
  output logic [1:0]               o_is_valid,
  input  logic [1:0]               i_usingNUM,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] free_slots;
  logic          ready;
  logic [1:0]    npush, npop, pop_req;
  logic          wr_en0, wr_en1;
  PC_set         wr_data0;
  PC_set         rd_data0, rd_data1;

  always_comb begin
    free_slots = CW'(DEPTH) - count_q;
    ready      = free_slots >= CW'(2);

    npush = ready ? ({1'b0, i_push[1]} + {1'b0, i_push[0]}) : 2'd0;

    // 2'b11 from dispatch means "two"; never pop more than is live
    pop_req = (i_usingNUM == 2'd0) ? 2'd0 : ((i_usingNUM == 2'd1) ? 2'd1 : 2'd2);
    npop    = (CW'(pop_req) > count_q) ? count_q[1:0] : pop_req;

    // A lone set2 is compressed into the tail slot so no hole is left
    wr_en0   = ready && (i_push != 2'b00) && !flush;
    wr_en1   = ready && (i_push == 2'b11) && !flush;
    wr_data0 = i_push[1] ? i_set1 : i_set2;

    head_d  = head_q + PW'(npop);
    tail_d  = tail_q + PW'(npush);
    count_d = count_q + CW'(npush) - CW'(npop);
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  iq_ram #(.DEPTH(DEPTH), .PW(PW)) u_ram (
    .clk      (clk),
    .wr_en0   (wr_en0),
    .wr_addr0 (tail_q),
    .wr_data0 (wr_data0),
    .wr_en1   (wr_en1),
    .wr_addr1 (tail_q + PW'(1)),
    .wr_data1 (i_set2),
    .rd_addr0 (head_q),
    .rd_data0 (rd_data0),
    .rd_addr1 (head_q + PW'(1)),
    .rd_data1 (rd_data1)
  );

  always_comb begin
    o_ready    = ready;
    o_count    = count_q;
    o_is_valid = {count_q >= CW'(1), count_q >= CW'(2)};
    o_set1         = rd_data0;
    o_set1.o_valid = o_is_valid[1];
    o_set2         = rd_data1;
    o_set2.o_valid = o_is_valid[0];
  end

endmodule

// File: tb/tb_decode_issue_queue.sv
// tb/tb_decode_issue_queue.sv - scoreboard bench for decode_issue_queue against a queue model
module tb_decode_issue_queue;
  import Public_Info::*;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          flush = 1'b0;
  PC_set         i_set1, i_set2, o_set1, o_set2;
  logic [1:0]    i_push = 2'b00;
  logic [1:0]    i_usingNUM = 2'b00;
  logic [1:0]    o_is_valid;
  logic          o_ready;
  logic [CW-1:0] o_count;

  decode_issue_queue #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .flush      (flush),
    .i_set1     (i_set1),
    .i_set2     (i_set2),
    .i_push     (i_push),
    .o_ready    (o_ready),
    .o_set1     (o_set1),
    .o_set2     (o_set2),
    .o_is_valid (o_is_valid),
    .i_usingNUM (i_usingNUM),
    .o_count    (o_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cnt;
    bit          rdy;
    bit [1:0]    vld;
    logic [31:0] pc1, pc2, in1, in2;
  } exp_t;

  exp_t  exp_q[$];
  PC_set model_q[$];
  int    n_cmp  = 0;
  int    n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic PC_set mk(input logic [31:0] pc);
    PC_set s;
    s.o_valid = 1'b1;
    s.PC      = pc;
    s.instr   = $urandom;
    s.op      = op_class_e'($urandom_range(0, 3));
    s.rd      = 5'($urandom);
    return s;
  endfunction

  // Drive one cycle and record what the queue must look like after the edge
  task automatic step(input bit r, input bit f, input bit [1:0] p,
                      input logic [31:0] pc1, input logic [31:0] pc2, input bit [1:0] u);
    int   sz;
    int   req;
    int   np;
    bit   rdy;
    exp_t e;
    @(negedge clk);
    rstn       = r;
    flush      = f;
    i_push     = p;
    i_set1     = mk(pc1);
    i_set2     = mk(pc2);
    i_usingNUM = u;
    if (!r || f) begin
      model_q.delete();
    end else begin
      sz  = model_q.size();
      rdy = (DEPTH - sz) >= 2;
      req = (u == 0) ? 0 : ((u == 1) ? 1 : 2);
      np  = (req < sz) ? req : sz;
      repeat (np) void'(model_q.pop_front());
      if (rdy) begin
        if (p[1]) model_q.push_back(i_set1);
        if (p[0]) model_q.push_back(i_set2);
      end
    end
    sz    = model_q.size();
    e.cnt = sz;
    e.rdy = (DEPTH - sz) >= 2;
    e.vld = {sz >= 1, sz >= 2};
    e.pc1 = '0; e.in1 = '0; e.pc2 = '0; e.in2 = '0;
    if (sz >= 1) begin e.pc1 = model_q[0].PC; e.in1 = model_q[0].instr; end
    if (sz >= 2) begin e.pc2 = model_q[1].PC; e.in2 = model_q[1].instr; end
    exp_q.push_back(e);
  endtask

  task automatic settle();
    @(posedge clk);
    #3;
  endtask

  initial begin
    forever begin
      exp_t e;
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("count", 32'(o_count), e.cnt);
        chk("ready", 32'(o_ready), 32'(e.rdy));
        chk("is_valid", 32'(o_is_valid), 32'(e.vld));
        chk("set1_vfield", 32'(o_set1.o_valid), 32'(e.vld[1]));
        chk("set2_vfield", 32'(o_set2.o_valid), 32'(e.vld[0]));
        if (e.vld[1]) begin
          chk("set1_pc", o_set1.PC, e.pc1);
          chk("set1_instr", o_set1.instr, e.in1);
        end
        if (e.vld[0]) begin
          chk("set2_pc", o_set2.PC, e.pc2);
          chk("set2_instr", o_set2.instr, e.in2);
        end
      end
    end
  end

  initial begin
    step(0, 0, 2'b00, 0, 0, 0);
    step(0, 0, 2'b11, 32'h1, 32'h2, 2);
    settle();
    chk("reset_count", 32'(o_count), 0);
    chk("reset_ready", 32'(o_ready), 1);
    chk("reset_valid", 32'(o_is_valid), 0);

    for (int k = 0; k < 3; k++)
      step(1, 0, 2'b11, 32'h1c000000 + 32'(8 * k), 32'h1c000004 + 32'(8 * k), 0);
    settle();
    chk("fill_count", 32'(o_count), 6);
    chk("fill_pc1", o_set1.PC, 32'h1c000000);
    chk("fill_pc2", o_set2.PC, 32'h1c000004);
    chk("fill_valid", 32'(o_is_valid), 3);
    chk("fill_ready", 32'(o_ready), 1);

    step(1, 0, 2'b11, 32'h1c000018, 32'h1c00001c, 0);
    settle();
    chk("full_count", 32'(o_count), 8);
    chk("full_ready", 32'(o_ready), 0);
    step(1, 0, 2'b11, 32'hdead0000, 32'hdead0004, 0);
    settle();
    chk("drop_count", 32'(o_count), 8);

    // Drain to head=6, then pop one while pushing set2 into index 0
    for (int k = 0; k < 3; k++) step(1, 0, 2'b00, 0, 0, 2);
    step(1, 0, 2'b01, 32'h0, 32'h000000b0, 1);
    settle();
    chk("wrap_pc1", o_set1.PC, 32'h1c00001c);
    chk("wrap_pc2", o_set2.PC, 32'h000000b0);
    step(1, 0, 2'b00, 0, 0, 2);
    settle();
    chk("wrap_valid", 32'(o_is_valid), 0);

    step(1, 0, 2'b00, 0, 0, 2);
    step(1, 0, 2'b10, 32'h000000c0, 32'h0, 0);
    step(1, 0, 2'b00, 0, 0, 2);
    settle();
    chk("overpop_count", 32'(o_count), 0);

    step(1, 0, 2'b11, 32'h10, 32'h14, 0);
    step(1, 0, 2'b10, 32'h18, 32'h0, 0);
    step(1, 0, 2'b01, 32'h0, 32'h000000a0, 2);
    settle();
    chk("mix_count", 32'(o_count), 2);
    chk("mix_pc2", o_set2.PC, 32'h000000a0);

    step(1, 0, 2'b11, 32'h20, 32'h24, 0);
    step(1, 0, 2'b10, 32'h28, 32'h0, 0);
    step(1, 1, 2'b11, 32'h30, 32'h34, 1);
    settle();
    chk("flush_count", 32'(o_count), 0);
    chk("flush_ready", 32'(o_ready), 1);

    step(1, 0, 2'b11, 32'h40, 32'h44, 0);
    step(1, 0, 2'b11, 32'h48, 32'h4c, 0);
    step(0, 0, 2'b11, 32'h50, 32'h54, 1);
    settle();
    chk("rst_mid_count", 32'(o_count), 0);

    for (int n = 0; n < 3000; n++)
      step($urandom_range(0, 99) != 0, $urandom_range(0, 49) == 0,
           2'($urandom), $urandom, $urandom, 2'($urandom));

    repeat (3) @(posedge clk);
    #3;
    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
